// File: rtl/fp_add_normalizer_pipe.sv
// Two-stage post-addition normaliser: leading-zero count in stage 1, shift/exponent adjust in stage 2.
// Optional subnormal output on underflow when FP_NORM_DENORM_EN is defined (default: flush to zero).
module fp_add_normalizer_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_e,
    input  logic [MAN_W:0]   in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_m,
    output logic             out_zero,
    output logic             out_oflow,
    output logic             out_uflow
);

    localparam int LZ_W = $clog2(MAN_W + 1);
    localparam int XW   = EXP_W + 1;
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    function automatic logic [LZ_W-1:0] count_lz(input logic [MAN_W-1:0] m);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (m[i]) n = LZ_W'(MAN_W - 1 - i);
        end
        return n;
    endfunction

    // Incremented exponent saturates at all-ones; the widened compare also catches e = all-ones.
    function automatic logic exp_inc_oflow(input logic [XW-1:0] inc);
        return inc >= EXP_MAX;
    endfunction

    logic             vld_p1, vld_p2;
    logic             adv1, adv2;
    logic             sign_p1;
    logic [EXP_W-1:0] e_p1;
    logic [MAN_W:0]   m_p1;
    logic [LZ_W-1:0]  lz_p1;

    logic             sign_p2, zero_p2, oflow_p2, uflow_p2;
    logic [EXP_W-1:0] e_p2;
    logic [MAN_W-1:0] m_p2;

    logic [XW-1:0]    e_x, lz_x, inc_x;
    logic [EXP_W-1:0] nxt_e;
    logic [MAN_W-1:0] nxt_m;
    logic             nxt_zero, nxt_oflow, nxt_uflow;
`ifdef FP_NORM_DENORM_EN
    logic [XW-1:0]    dn_sh;
`endif

    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    // Stage 1: capture operands and leading-zero count on accept
    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            sign_p1 <= in_sign;
            e_p1    <= in_e;
            m_p1    <= in_m;
            lz_p1   <= count_lz(in_m[MAN_W-1:0]);
        end
    end

    // Stage 2: case selection in priority carry > zero > normal > underflow
    always_comb begin
        e_x       = {1'b0, e_p1};
        lz_x      = XW'(lz_p1);
        inc_x     = e_x + XW'(1);
        nxt_e     = '0;
        nxt_m     = '0;
        nxt_zero  = 1'b0;
        nxt_oflow = 1'b0;
        nxt_uflow = 1'b0;
`ifdef FP_NORM_DENORM_EN
        dn_sh     = (e_x >= XW'(1)) ? e_x - XW'(1) : '0;
`endif
        if (m_p1[MAN_W]) begin
            if (exp_inc_oflow(inc_x)) begin
                nxt_e     = '1;
                nxt_oflow = 1'b1;
            end else begin
                nxt_e = inc_x[EXP_W-1:0];
                nxt_m = m_p1[MAN_W:1];
            end
        end else if (m_p1 == '0) begin
            nxt_zero = 1'b1;
        end else if (lz_x < e_x) begin
            nxt_e = EXP_W'(e_x - lz_x);
            nxt_m = m_p1[MAN_W-1:0] << lz_p1;
        end else begin
            nxt_uflow = 1'b1;
`ifdef FP_NORM_DENORM_EN
            nxt_m    = m_p1[MAN_W-1:0] << dn_sh;
            nxt_zero = (nxt_m == '0);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            sign_p2  <= 1'b0;
            e_p2     <= '0;
            m_p2     <= '0;
            zero_p2  <= 1'b0;
            oflow_p2 <= 1'b0;
            uflow_p2 <= 1'b0;
        end else begin
            if (adv1) vld_p1 <= in_valid;
            if (adv2) vld_p2 <= vld_p1;
            if (adv2 && vld_p1) begin
                sign_p2  <= sign_p1;
                e_p2     <= nxt_e;
                m_p2     <= nxt_m;
                zero_p2  <= nxt_zero;
                oflow_p2 <= nxt_oflow;
                uflow_p2 <= nxt_uflow;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_sign  = sign_p2;
    assign out_e     = e_p2;
    assign out_m     = m_p2;
    assign out_zero  = zero_p2;
    assign out_oflow = oflow_p2;
    assign out_uflow = uflow_p2;

endmodule

// File: tb/tb_fp_add_normalizer_pipe.sv
// Directed bench for fp_add_normalizer_pipe (EXP_W=8, MAN_W=24) with an in-order scoreboard.
// Expected underflow results follow FP_NORM_DENORM_EN when it is defined.
module tb_fp_add_normalizer_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam int NV    = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [EXP_W-1:0] in_e = '0;
    logic [MAN_W:0]   in_m = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sign;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_m;
    logic             out_zero, out_oflow, out_uflow;

    fp_add_normalizer_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_e(in_e), .in_m(in_m),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_e(out_e), .out_m(out_m),
        .out_zero(out_zero), .out_oflow(out_oflow), .out_uflow(out_uflow)
    );

    always #5 clk = ~clk;

    // {sign, e, m, zero, oflow, uflow}
    logic [35:0] outs;
    assign outs = {out_sign, out_e, out_m, out_zero, out_oflow, out_uflow};

    logic [EXP_W-1:0] ve [NV];
    logic [MAN_W:0]   vm [NV];
    logic [EXP_W-1:0] xe [NV];
    logic [MAN_W-1:0] xm [NV];
    logic [2:0]       xf [NV];

    int nerr = 0;
    int nchk = 0;
    int q[$];
    int ndone;
    logic have_hold;
    logic [35:0] held;
    logic saw_full;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] expv(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk[0], xe[k], xm[k], xf[k]};
    endfunction

    task automatic step(input logic iv, input int idx, input logic ordy);
        int k;
        logic [31:0] ii;
        @(negedge clk);
        ii       = idx;
        in_valid = iv;
        in_sign  = ii[0];
        in_e     = ve[idx];
        in_m     = vm[idx];
        out_ready = ordy;
        #1;
        if (have_hold && out_valid) check("stall_hold", 64'(outs), 64'(held));
        have_hold = out_valid && !out_ready;
        held      = outs;
        if (!in_ready) saw_full = 1'b1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
            else begin
                k = q.pop_front();
                check($sformatf("data_v%0d", k), 64'(outs), 64'(expv(k)));
                ndone++;
            end
        end
        if (in_valid && in_ready) q.push_back(idx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        have_hold = 1'b0;
    endtask

    initial begin
        ve[0] = 8'h80; vm[0] = 25'h0800000; xe[0] = 8'h80; xm[0] = 24'h800000; xf[0] = 3'b000;
        ve[1] = 8'h80; vm[1] = 25'h1000001; xe[1] = 8'h81; xm[1] = 24'h800000; xf[1] = 3'b000;
        ve[2] = 8'hFE; vm[2] = 25'h1800000; xe[2] = 8'hFF; xm[2] = 24'h000000; xf[2] = 3'b010;
        ve[3] = 8'h80; vm[3] = 25'h0000001; xe[3] = 8'h69; xm[3] = 24'h800000; xf[3] = 3'b000;
        ve[4] = 8'h80; vm[4] = 25'h0000000; xe[4] = 8'h00; xm[4] = 24'h000000; xf[4] = 3'b100;
        ve[7] = 8'hFF; vm[7] = 25'h1000000; xe[7] = 8'hFF; xm[7] = 24'h000000; xf[7] = 3'b010;
        ve[8] = 8'h02; vm[8] = 25'h0400000; xe[8] = 8'h01; xm[8] = 24'h800000; xf[8] = 3'b000;
        ve[5] = 8'h05; vm[5] = 25'h0000100; xe[5] = 8'h00; xf[5] = 3'b001;
        ve[6] = 8'h01; vm[6] = 25'h0400000; xe[6] = 8'h00; xf[6] = 3'b001;
        ve[9] = 8'h00; vm[9] = 25'h0800000; xe[9] = 8'h00; xf[9] = 3'b001;
`ifdef FP_NORM_DENORM_EN
        xm[5] = 24'h001000; xm[6] = 24'h400000; xm[9] = 24'h800000;
`else
        xm[5] = 24'h000000; xm[6] = 24'h000000; xm[9] = 24'h000000;
`endif
        have_hold = 1'b0;
        saw_full  = 1'b0;
        ndone     = 0;

        // reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outs", 64'(outs), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // latency with a single beat
        step(1'b1, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        check("lat_cycle1", 64'(out_valid), 64'(0));
        step(1'b0, 0, 1'b1);
        check("lat_cycle2", 64'(ndone), 64'(1));

        // full-rate stream of all vectors
        ndone = 0;
        for (int i = 0; i < NV; i++) step(1'b1, i, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
        check("stream_count", 64'(ndone), 64'(NV));

        // backpressure: 5 beats, out_ready low in cycles 3..5
        begin
            int nxt;
            int c;
            nxt = 0; c = 0; ndone = 0; saw_full = 1'b0;
            while (ndone < 5 && c < 40) begin
                c++;
                step(nxt < 5, nxt < 5 ? nxt : 0, !(c >= 3 && c <= 5));
                if (q.size() > 0 && q[q.size()-1] == nxt && nxt < 5) nxt++;
            end
            check("bp_count", 64'(ndone), 64'(5));
            check("bp_in_ready_low", 64'(saw_full), 64'(1));
            check("bp_queue_empty", 64'(q.size()), 64'(0));
        end

        // reset with two beats in flight
        step(1'b1, 1, 1'b0);
        step(1'b1, 3, 1'b0);
        do_reset();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_outs", 64'(outs), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        ndone = 0;
        step(1'b1, 3, 1'b1);
        step(1'b0, 0, 1'b1);
        check("post_rst_lat1", 64'(out_valid), 64'(0));
        step(1'b0, 0, 1'b1);
        check("post_rst_lat2", 64'(ndone), 64'(1));
        step(1'b0, 0, 1'b1);
        check("post_rst_idle", 64'(out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
